// File: rtl/ip_packet_builder.sv
// IPv4 packet builder: emits a 5-word IPv4 header followed by forwarded payload
// words as a 32-bit stream with sof/eof/keep framing.
`timescale 1ns/1ps

module ip_packet_builder #(
    parameter logic [7:0]  TTL_DEFAULT = 8'h40,
    parameter logic [15:0] MAX_PAYLOAD = 16'd65515
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [7:0]  protocol,
    input  logic [7:0]  ttl_in,
    input  logic [15:0] payload_len,
    input  logic [31:0] pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        sof,
    output logic        eof,
    output logic [3:0]  keep,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned W_DATA  = 32;
    localparam int unsigned W_HALF  = 16;
    localparam int unsigned W_SUM   = 20;
    localparam int unsigned W_WLEFT = 15;
    localparam int unsigned W_IDX   = 3;
    localparam int unsigned W_KEEP  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_FOLD,
        S_HDR,
        S_PAY,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [W_DATA-1:0]   src_q, src_d;
    logic [W_DATA-1:0]   dst_q, dst_d;
    logic [7:0]          proto_q, proto_d;
    logic [7:0]          ttl_q, ttl_d;
    logic [W_HALF-1:0]   plen_q, plen_d;
    logic [W_HALF-1:0]   tlen_q, tlen_d;
    logic [W_HALF-1:0]   id_q, id_d;
    logic [W_SUM-1:0]    sum_q, sum_d;
    logic [W_HALF-1:0]   csum_q, csum_d;
    logic [W_IDX-1:0]    idx_q, idx_d;
    logic [W_WLEFT-1:0]  wleft_q, wleft_d;

    logic [W_DATA-1:0]   data_d;
    logic                valid_d, sof_d, eof_d, busy_d, done_d, err_d;
    logic [W_KEEP-1:0]   keep_d;

    logic                load_ok;
    logic [W_SUM-1:0]    sum_all;
    logic [W_HALF:0]     fold1;
    logic [W_HALF-1:0]   fold2;
    logic [W_DATA-1:0]   hdr_word;
    logic [W_KEEP-1:0]   last_keep;

    // Output register may take a new word when empty or draining this cycle.
    assign load_ok   = !data_valid || data_ready;
    assign pay_ready = (state_q == S_PAY) && load_ok;

    // Header checksum: checksum field itself contributes zero.
    assign sum_all = W_SUM'(16'h4500) + W_SUM'(tlen_q) + W_SUM'(id_q) + W_SUM'(16'h4000)
                   + W_SUM'({ttl_q, proto_q})
                   + W_SUM'(src_q[31:16]) + W_SUM'(src_q[15:0])
                   + W_SUM'(dst_q[31:16]) + W_SUM'(dst_q[15:0]);

    assign fold1 = (W_HALF+1)'(sum_q[15:0]) + (W_HALF+1)'(sum_q[19:16]);
    assign fold2 = fold1[W_HALF-1:0] + W_HALF'(fold1[W_HALF]);

    always_comb begin
        hdr_word = '0;
        case (idx_q)
            3'd0:    hdr_word = {8'h45, 8'h00, tlen_q};
            3'd1:    hdr_word = {id_q, 16'h4000};
            3'd2:    hdr_word = {ttl_q, proto_q, csum_q};
            3'd3:    hdr_word = src_q;
            3'd4:    hdr_word = dst_q;
            default: hdr_word = '0;
        endcase
    end

    always_comb begin
        last_keep = 4'hF;
        case (plen_q[1:0])
            2'd0:    last_keep = 4'hF;
            2'd1:    last_keep = 4'h8;
            2'd2:    last_keep = 4'hC;
            default: last_keep = 4'hE;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        proto_d = proto_q;
        ttl_d   = ttl_q;
        plen_d  = plen_q;
        tlen_d  = tlen_q;
        id_d    = id_q;
        sum_d   = sum_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        wleft_d = wleft_q;
        data_d  = data_out;
        valid_d = data_valid;
        sof_d   = sof;
        eof_d   = eof;
        keep_d  = keep;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            src_d   = '0;
            dst_d   = '0;
            proto_d = '0;
            ttl_d   = '0;
            plen_d  = '0;
            tlen_d  = '0;
            id_d    = '0;
            sum_d   = '0;
            csum_d  = '0;
            idx_d   = '0;
            wleft_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
            keep_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (payload_len > MAX_PAYLOAD) begin
                            err_d = 1'b1;
                        end else begin
                            src_d   = src_ip;
                            dst_d   = dst_ip;
                            proto_d = protocol;
                            ttl_d   = (ttl_in == 8'd0) ? TTL_DEFAULT : ttl_in;
                            plen_d  = payload_len;
                            tlen_d  = payload_len + 16'd20;
                            state_d = S_SUM;
                        end
                    end
                end
                S_SUM: begin
                    sum_d   = sum_all;
                    state_d = S_FOLD;
                end
                S_FOLD: begin
                    csum_d  = ~fold2;
                    idx_d   = '0;
                    state_d = S_HDR;
                end
                S_HDR: begin
                    if (load_ok) begin
                        valid_d = 1'b1;
                        data_d  = hdr_word;
                        sof_d   = (idx_q == 3'd0);
                        eof_d   = 1'b0;
                        keep_d  = 4'hF;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd4) begin
                            if (plen_q == 16'd0) begin
                                eof_d   = 1'b1;
                                state_d = S_FIN;
                            end else begin
                                wleft_d = W_WLEFT'((17'(plen_q) + 17'd3) >> 2);
                                state_d = S_PAY;
                            end
                        end
                    end
                end
                S_PAY: begin
                    if (load_ok) begin
                        sof_d = 1'b0;
                        if (pay_valid) begin
                            valid_d = 1'b1;
                            data_d  = pay_data;
                            wleft_d = wleft_q - 15'd1;
                            if (wleft_q == 15'd1) begin
                                eof_d   = 1'b1;
                                keep_d  = last_keep;
                                state_d = S_FIN;
                            end else begin
                                eof_d  = 1'b0;
                                keep_d = 4'hF;
                            end
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
                S_FIN: begin
                    if (data_valid && data_ready) begin
                        valid_d = 1'b0;
                        sof_d   = 1'b0;
                        eof_d   = 1'b0;
                        done_d  = 1'b1;
                        id_d    = id_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            proto_q    <= '0;
            ttl_q      <= '0;
            plen_q     <= '0;
            tlen_q     <= '0;
            id_q       <= '0;
            sum_q      <= '0;
            csum_q     <= '0;
            idx_q      <= '0;
            wleft_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            keep       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            proto_q    <= proto_d;
            ttl_q      <= ttl_d;
            plen_q     <= plen_d;
            tlen_q     <= tlen_d;
            id_q       <= id_d;
            sum_q      <= sum_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            wleft_q    <= wleft_d;
            data_out   <= data_d;
            data_valid <= valid_d;
            sof        <= sof_d;
            eof        <= eof_d;
            keep       <= keep_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule
